if_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register; feeds ID's instruction and pc inputs.

---
 rtl/if_stage_pkg.sv | 28 ++
 rtl/if_stage_if_id_reg.sv | 52 +++++
 rtl/if_stage.sv | 171 +++++++++++++++++
 tb/tb_if_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants, state encoding and small helpers for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSN = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  typedef enum logic [1:0] {
    ST_REQ  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } fetch_word_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Wraps modulo 2^32, so 0xFFFF_FFFC steps to 0x0000_0000.
  function automatic logic [31:0] next_pc(input logic [31:0] addr);
    return addr + PC_STEP;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: instruction, pc and valid with flush > hold > load priority.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSN = DEFAULT_NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] load_insn,
  input  logic [31:0] load_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        if_valid
);

  logic [31:0] insn_r;
  logic [31:0] pc_r;
  logic        valid_r;

  // Register update; an idle unstalled cycle inserts a bubble but keeps the last pc
  always_ff @(posedge clk) begin
    if (rst) begin
      insn_r  <= NOP_INSN;
      pc_r    <= 32'h0000_0000;
      valid_r <= 1'b0;
    end else if (flush) begin
      insn_r  <= NOP_INSN;
      pc_r    <= pc_r;
      valid_r <= 1'b0;
    end else if (hold) begin
      insn_r  <= insn_r;
      pc_r    <= pc_r;
      valid_r <= valid_r;
    end else if (load) begin
      insn_r  <= load_insn;
      pc_r    <= load_pc;
      valid_r <= 1'b1;
    end else begin
      insn_r  <= NOP_INSN;
      pc_r    <= pc_r;
      valid_r <= 1'b0;
    end
  end

  assign instruction = insn_r;
  assign pc          = pc_r;
  assign if_valid    = valid_r;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, stall skid buffer,
// redirect handling and the IF/ID register feeding decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSN = DEFAULT_NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] pc_imm,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        if_valid
);

  fetch_state_e state_r;
  logic         req_r;
  logic [31:0]  pc_r;
  logic [31:0]  fetch_pc_r;
  logic         drop_r;
  logic         skid_valid_r;
  fetch_word_t  skid_r;

  logic         load_s;
  fetch_word_t  load_word_s;

  // req_r mirrors "state is REQ"; rst gates it so no request leaks while reset is held
  assign imem_req  = req_r & ~rst;
  assign imem_addr = pc_r;

  // Select what the IF/ID register would take this cycle: fresh response or skid contents
  always_comb begin
    load_s      = 1'b0;
    load_word_s = '{insn: imem_rdata, pc: fetch_pc_r};
    case (state_r)
      ST_WAIT: begin
        load_s      = imem_rvalid & ~drop_r & ~stall;
        load_word_s = '{insn: imem_rdata, pc: fetch_pc_r};
      end
      ST_HOLD: begin
        load_s      = skid_valid_r & ~stall;
        load_word_s = skid_r;
      end
      default: begin
        load_s      = 1'b0;
        load_word_s = '{insn: imem_rdata, pc: fetch_pc_r};
      end
    endcase
  end

  // Fetch FSM with PC, skid and drop flag; a redirect overrides every other transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_REQ;
      req_r        <= 1'b1;
      pc_r         <= RESET_PC;
      fetch_pc_r   <= RESET_PC;
      drop_r       <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_r       <= '{insn: NOP_INSN, pc: 32'h0000_0000};
    end else if (PCSrc) begin
      pc_r         <= align_word(pc_imm);
      skid_valid_r <= 1'b0;
      case (state_r)
        ST_WAIT: begin
          if (imem_rvalid) begin
            state_r <= ST_REQ;
            req_r   <= 1'b1;
            drop_r  <= 1'b0;
          end else begin
            // response still owed for the abandoned fetch
            state_r <= ST_WAIT;
            req_r   <= 1'b0;
            drop_r  <= 1'b1;
          end
        end
        ST_REQ: begin
          if (imem_gnt) begin
            state_r <= ST_WAIT;
            req_r   <= 1'b0;
            drop_r  <= 1'b1;
          end else begin
            state_r <= ST_REQ;
            req_r   <= 1'b1;
            drop_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_REQ;
          req_r   <= 1'b1;
          drop_r  <= 1'b0;
        end
      endcase
    end else begin
      case (state_r)
        ST_REQ: begin
          if (imem_gnt) begin
            fetch_pc_r <= pc_r;
            state_r    <= ST_WAIT;
            req_r      <= 1'b0;
          end else begin
            state_r <= ST_REQ;
            req_r   <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (drop_r) begin
              drop_r  <= 1'b0;
              state_r <= ST_REQ;
              req_r   <= 1'b1;
            end else if (!stall) begin
              pc_r    <= next_pc(fetch_pc_r);
              state_r <= ST_REQ;
              req_r   <= 1'b1;
            end else begin
              skid_r       <= '{insn: imem_rdata, pc: fetch_pc_r};
              skid_valid_r <= 1'b1;
              pc_r         <= next_pc(fetch_pc_r);
              state_r      <= ST_HOLD;
              req_r        <= 1'b0;
            end
          end else begin
            state_r <= ST_WAIT;
            req_r   <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            skid_valid_r <= 1'b0;
            state_r      <= ST_REQ;
            req_r        <= 1'b1;
          end else begin
            state_r <= ST_HOLD;
            req_r   <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_REQ;
          req_r        <= 1'b1;
          drop_r       <= 1'b0;
          skid_valid_r <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSN(NOP_INSN)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (PCSrc),
    .hold       (stall),
    .load       (load_s),
    .load_insn  (load_word_s.insn),
    .load_pc    (load_word_s.pc),
    .instruction(instruction),
    .pc         (pc),
    .if_valid   (if_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios, then random stall/redirect/reset
// traffic against a program-order reference model and a randomly timed memory.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] pc_imm = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        if_valid;

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSN(NOP_INSN)) dut (
    .clk(clk), .rst(rst), .stall(stall), .PCSrc(PCSrc), .pc_imm(pc_imm),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc(pc), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // memory behaviour knobs and single-outstanding bookkeeping
  int          gnt_pct = 100;
  int          dly_min = 1;
  int          dly_max = 1;
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;

  // reference model: expected IF/ID contents and the next pc in program order
  logic        m_valid = 1'b0;
  logic [31:0] m_insn = NOP_INSN;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] exp_pc = RESET_PC;
  int          deliveries = 0;

  logic        snap_req;
  logic        snap_gnt;
  logic [31:0] snap_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_check(input logic r, input logic s, input logic p, input logic [31:0] imm);
    if (r) begin
      m_valid = 1'b0;
      m_insn  = NOP_INSN;
      m_pc    = 32'h0;
      exp_pc  = RESET_PC;
      chk("req_during_rst", 32'(imem_req), 32'd0);
    end else if (p) begin
      m_valid = 1'b0;
      m_insn  = NOP_INSN;
      exp_pc  = imm & 32'hFFFF_FFFC;
    end else if (s) begin
      m_valid = m_valid;
    end else if (if_valid) begin
      m_valid = 1'b1;
      m_pc    = exp_pc;
      m_insn  = mem_word(exp_pc);
      exp_pc  = exp_pc + 32'd4;
      deliveries++;
    end else begin
      m_valid = 1'b0;
      m_insn  = NOP_INSN;
    end
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    chk("instruction", instruction, m_insn);
    chk("pc", pc, m_pc);
  endtask

  // one clock cycle: drive inputs and memory at negedge, check after the rising edge
  task automatic step(input logic r, input logic s, input logic p, input logic [31:0] imm);
    @(negedge clk);
    rst    = r;
    stall  = s;
    PCSrc  = p;
    pc_imm = imm;
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_busy && mem_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr);
    end
    imem_gnt = 1'b0;
    if (!mem_busy && imem_req && ($urandom_range(99) < gnt_pct)) imem_gnt = 1'b1;
    snap_req  = imem_req;
    snap_gnt  = imem_gnt;
    snap_addr = imem_addr;
    @(posedge clk);
    #1;
    if (imem_rvalid) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (snap_gnt) begin
      mem_busy = 1'b1;
      mem_addr = snap_addr;
      mem_cnt  = int'($urandom_range(dly_max, dly_min)) - 1;
    end
    model_check(r, s, p, imm);
    chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
    if (!r && !p && snap_req && !snap_gnt && imem_req)
      chk("addr_stable", imem_addr, snap_addr);
  endtask

  initial begin
    logic        r_v, s_v, p_v;
    logic [31:0] imm_v;

    // reset then a 1-cycle memory fetch from 0x0
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t1_req", 32'(snap_req), 32'd1);
    chk("t1_req_addr", snap_addr, RESET_PC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t1_valid", 32'(if_valid), 32'd1);
    chk("t1_insn", instruction, 32'h0050_0093);
    chk("t1_pc", pc, 32'h0);
    chk("t1_next_addr", imem_addr, 32'h4);

    // response arrives under stall: parked in skid, released when stall drops
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t2_req_hold", 32'(imem_req), 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("t2_req_hold2", 32'(imem_req), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t2_skid_valid", 32'(if_valid), 32'd1);
    chk("t2_skid_pc", pc, 32'h4);
    chk("t2_skid_insn", instruction, mem_word(32'h4));
    chk("t2_req_resume", 32'(imem_req), 32'd1);
    chk("t2_next_addr", imem_addr, 32'h8);

    // redirect while waiting on a slow response; late data is discarded
    dly_min = 3; dly_max = 3;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    chk("t3_flush_valid", 32'(if_valid), 32'd0);
    chk("t3_flush_insn", instruction, NOP_INSN);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t3_still_wait", 32'(imem_req), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t3_req", 32'(imem_req), 32'd1);
    chk("t3_addr", imem_addr, 32'h0000_0100);
    chk("t3_no_late_data", 32'(if_valid), 32'd0);
    dly_min = 1; dly_max = 1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t3_target_pc", pc, 32'h0000_0100);

    // redirect and stall together: flush wins, stale grant dropped
    step(1'b0, 1'b1, 1'b1, 32'h0000_0040);
    chk("t4_valid", 32'(if_valid), 32'd0);
    chk("t4_insn", instruction, 32'h0000_0013);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t4_target_pc", pc, 32'h0000_0040);

    // pc wraps from the top of the address space
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t5_top_pc", pc, 32'hFFFF_FFFC);
    chk("t5_top_valid", 32'(if_valid), 32'd1);
    chk("t5_wrap_addr", imem_addr, 32'h0000_0000);

    // reset during a fetch; its response arrives after reset and is ignored
    dly_min = 2; dly_max = 2;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t6_rvalid_seen", 32'(imem_rvalid), 32'd1);
    chk("t6_addr", imem_addr, RESET_PC);
    chk("t6_valid", 32'(if_valid), 32'd0);
    dly_min = 1; dly_max = 1;
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("t6_refetch_valid", 32'(if_valid), 32'd1);
    chk("t6_refetch_pc", pc, RESET_PC);

    // random traffic against the reference model
    gnt_pct = 70; dly_min = 1; dly_max = 4;
    for (int i = 0; i < 1500; i++) begin
      r_v   = ($urandom_range(199) == 0);
      s_v   = ($urandom_range(3) == 0);
      p_v   = ($urandom_range(19) == 0);
      imm_v = $urandom;
      step(r_v, s_v, p_v, imm_v);
    end
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("forward_progress", 32'(deliveries >= 60), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
